// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory stage.
package lsu_pkg;

  // RV32 load/store funct3 codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Data-memory access-size encodings (equal to funct3[1:0] for legal codes)
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_LOAD_WAIT,
    ST_RESP
  } lsu_state_e;

  // Stores only have the signed-looking codes; unsigned variants are loads only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Number of bytes touched for a given access size.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load-data extension: picks the right-aligned byte/half/word and extends it.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] result
);

  // Sign- or zero-extend according to the load type
  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{word[7]}}, word[7:0]};
      F3_H:    result = {{16{word[15]}}, word[15:0]};
      F3_W:    result = word;
      F3_BU:   result = {24'h000000, word[7:0]};
      F3_HU:   result = {16'h0000, word[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: validates one request at a time, drives the data memory,
// extends load data and holds the response until it is consumed.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h01000000,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read_write,
  output logic [1:0]  mem_access_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  lsu_state_e  state, state_nxt;
  logic        we_r;
  logic [2:0]  f3_r;
  logic        accept;
  logic        bad_f3, misaligned, out_of_range, req_bad;
  logic [32:0] span;
  logic [31:0] load_ext;

  assign accept = req_valid && req_ready;

  // Request legality, evaluated on the raw request so the error path skips memory
  always_comb begin
    bad_f3     = !f3_legal(req_we, req_funct3);
    misaligned = ((req_funct3[1:0] == SZ_HALF) && req_addr[0]) ||
                 ((req_funct3[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
    // Below-BASE is checked separately since the offset would wrap to a small value
    span         = {1'b0, req_addr - BASE} + {30'b0, size_bytes(req_funct3[1:0])};
    out_of_range = (req_addr < BASE) || (span > 33'(MEM_DEPTH));
    req_bad      = bad_f3 || misaligned || out_of_range;
  end

  lsu_load_extend u_extend (
    .funct3 (f3_r),
    .word   (mem_data_out),
    .result (load_ext)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded outputs; strobe is combinational so reset drops it at once
  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_read_write = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_bad ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_read_write = we_r;
        state_nxt      = we_r ? ST_RESP : ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: state_nxt = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture and response data.
  // Address/wdata/size are captured straight into the mem_* registers, and only
  // for legal requests, so those ports keep their last values across error responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_r            <= 1'b0;
      f3_r            <= '0;
      mem_address     <= BASE;
      mem_data_in     <= '0;
      mem_access_size <= '0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
    end else begin
      if (accept) begin
        we_r       <= req_we;
        f3_r       <= req_funct3;
        resp_err   <= req_bad;
        resp_rdata <= '0;
        if (!req_bad) begin
          mem_address     <= req_addr;
          mem_data_in     <= req_wdata;
          mem_access_size <= req_funct3[1:0];
        end
      end
      if (state == ST_LOAD_WAIT) resp_rdata <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage with a behavioural data memory.
module tb_lsu_mem_stage;

  localparam logic [31:0] BASE  = 32'h01000000;
  localparam int unsigned DEPTH = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_address, mem_data_in, mem_data_out;

  lsu_mem_stage #(.BASE(BASE), .MEM_DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_read_write  (mem_read_write),
    .mem_access_size (mem_access_size),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Behavioural data memory: registered, little-endian, right-aligned read data
  logic [7:0]  mem [DEPTH];
  logic        mem_init;
  int unsigned moff, nb;
  logic [31:0] rd;
  always @(posedge clock) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      mem_data_out <= '0;
    end else begin
      moff = mem_address - BASE;
      nb = (mem_access_size == 2'd0) ? 1 : (mem_access_size == 2'd1) ? 2 : 4;
      if (mem_read_write)
        for (int unsigned k = 0; k < 4; k++)
          if (k < nb && moff + k < DEPTH) mem[moff + k] <= mem_data_in[8*k +: 8];
      for (int unsigned k = 0; k < 4; k++)
        rd[8*k +: 8] = (moff + k < DEPTH) ? mem[moff + k] : 8'h00;
      mem_data_out <= rd;
    end
  end

  // Write-strobe monitor
  int          strobe_cnt;
  logic [1:0]  strobe_size;
  logic [31:0] strobe_addr;
  always @(negedge clock) begin
    if (mem_read_write === 1'b1) begin
      strobe_cnt  = strobe_cnt + 1;
      strobe_size = mem_access_size;
      strobe_addr = mem_address;
    end
  end

  // Reference memory and scoreboard
  logic [7:0] ref_mem [DEPTH];
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          strobes;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned off);
    logic [7:0] b0, b1, b2, b3;
    b0 = ref_mem[off];
    b1 = (off + 1 < DEPTH) ? ref_mem[off + 1] : 8'h00;
    b2 = (off + 2 < DEPTH) ? ref_mem[off + 2] : 8'h00;
    b3 = (off + 3 < DEPTH) ? ref_mem[off + 3] : 8'h00;
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'h000000, b0};
      3'b101:  return {16'h0000, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold, input string name);
    exp_t e, got;
    int   n, lat;
    bit   seen;
    int unsigned off, nbytes;
    e.rdata   = exp_rdata;
    e.err     = exp_err;
    e.lat     = exp_err ? 1 : (we ? 2 : 3);
    e.strobes = (!exp_err && we) ? 1 : 0;
    sb.push_back(e);
    if (we && !exp_err) begin
      off    = addr - BASE;
      nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      for (int unsigned k = 0; k < nbytes; k++) ref_mem[off + k] = wdata[8*k +: 8];
    end
    @(negedge clock);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready);
      void'(sb.pop_front());
      return;
    end
    passed++;
    strobe_cnt = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clock);
    #1 req_valid = 1'b0;
    req_we    = 1'b0;
    req_wdata = $urandom;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 10) begin
      @(negedge clock);
      lat++;
      if (resp_valid === 1'b1) seen = 1;
    end
    got = sb.pop_front();
    checks++;
    if (!seen) begin
      $display("FAIL %s resp_timeout: resp_valid=%b required 1 within 10 cycles", name, resp_valid);
      return;
    end
    passed++;
    checks++;
    if (lat !== got.lat) $display("FAIL %s latency: got %0d required %0d", name, lat, got.lat);
    else passed++;
    checks++;
    if (resp_rdata !== got.rdata)
      $display("FAIL %s rdata: got %h required %h", name, resp_rdata, got.rdata);
    else passed++;
    checks++;
    if (resp_err !== got.err) $display("FAIL %s err: got %b required %b", name, resp_err, got.err);
    else passed++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== got.rdata || resp_err !== got.err || req_ready !== 1'b0)
        $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                 name, i, resp_valid, resp_rdata, resp_err, req_ready, got.rdata, got.err);
      else passed++;
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL %s release: req_ready=%b resp_valid=%b required 1 0", name, req_ready, resp_valid);
    else passed++;
    checks++;
    if (strobe_cnt !== got.strobes)
      $display("FAIL %s strobes: got %0d required %0d", name, strobe_cnt, got.strobes);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0)
      $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h required 1 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata);
    else passed++;
    checks++;
    if (mem_read_write !== 1'b0 || mem_access_size !== 2'd0 || mem_address !== BASE || mem_data_in !== 32'h0)
      $display("FAIL reset_mem: rw=%b size=%0d addr=%h din=%h required 0 0 %h 0",
               mem_read_write, mem_access_size, mem_address, mem_data_in, BASE);
    else passed++;
    @(negedge clock);
    reset    = 1'b0;
    mem_init = 1'b0;
  endtask

  task automatic test_store_load();
    do_req(1'b1, 3'b010, BASE + 4, 32'hDEADBEEF, 32'h0, 1'b0, 0, "sw_base4");
    checks++;
    if (strobe_size !== 2'd2 || strobe_addr !== BASE + 4)
      $display("FAIL sw_strobe_info: size=%0d addr=%h required 2 %h", strobe_size, strobe_addr, BASE + 4);
    else passed++;
    do_req(1'b0, 3'b010, BASE + 4, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw_base4");
  endtask

  task automatic test_extend();
    do_req(1'b0, 3'b000, BASE + 7, 32'h0, 32'hFFFFFFDE, 1'b0, 0, "lb_base7");
    do_req(1'b0, 3'b100, BASE + 7, 32'h0, 32'h000000DE, 1'b0, 0, "lbu_base7");
    do_req(1'b0, 3'b001, BASE + 4, 32'h0, 32'hFFFFBEEF, 1'b0, 0, "lh_base4");
    do_req(1'b0, 3'b101, BASE + 6, 32'h0, 32'h0000DEAD, 1'b0, 0, "lhu_base6");
  endtask

  task automatic test_errors();
    do_req(1'b0, 3'b010, BASE + 2, 32'h0, 32'h0, 1'b1, 0, "lw_misalign");
    do_req(1'b1, 3'b001, BASE + 1, 32'h11112222, 32'h0, 1'b1, 0, "sh_misalign");
    do_req(1'b0, 3'b010, BASE + DEPTH - 2, 32'h0, 32'h0, 1'b1, 0, "lw_past_end");
    do_req(1'b1, 3'b000, BASE - 1, 32'h000000AA, 32'h0, 1'b1, 0, "sb_below_base");
    do_req(1'b0, 3'b011, BASE, 32'h0, 32'h0, 1'b1, 0, "f3_011_load");
    do_req(1'b1, 3'b011, BASE + 4, 32'h55555555, 32'h0, 1'b1, 0, "f3_011_store");
    do_req(1'b1, 3'b100, BASE + 4, 32'h66666666, 32'h0, 1'b1, 0, "f3_100_store");
    do_req(1'b1, 3'b010, BASE + DEPTH, 32'h77777777, 32'h0, 1'b1, 0, "sw_at_end");
    do_req(1'b0, 3'b010, BASE + 4, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw_reread");
    do_req(1'b1, 3'b010, BASE + DEPTH - 4, 32'hCAFEF00D, 32'h0, 1'b0, 0, "sw_last_word");
    do_req(1'b0, 3'b010, BASE + DEPTH - 4, 32'h0, 32'hCAFEF00D, 1'b0, 0, "lw_last_word");
    do_req(1'b0, 3'b000, BASE + DEPTH - 1, 32'h0, 32'hFFFFFFCA, 1'b0, 0, "lb_last_byte");
  endtask

  task automatic test_hold();
    do_req(1'b0, 3'b001, BASE + 4, 32'h0, 32'hFFFFBEEF, 1'b0, 5, "lh_hold");
    do_req(1'b0, 3'b010, BASE + 2, 32'h0, 32'h0, 1'b1, 5, "err_hold");
  endtask

  task automatic test_reset_in_access();
    @(negedge clock);
    strobe_cnt = 0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = BASE + 8;
    req_wdata  = 32'h12345678;
    @(posedge clock);
    #1 req_valid = 1'b0;
    req_we = 1'b0;
    checks++;
    if (mem_read_write !== 1'b1) $display("FAIL rst_access_strobe: got %b required 1", mem_read_write);
    else passed++;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (mem_read_write !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL rst_async: rw=%b ready=%b valid=%b required 0 1 0", mem_read_write, req_ready, resp_valid);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
        $display("FAIL rst_after%0d: valid=%b ready=%b required 0 1", i, resp_valid, req_ready);
      else passed++;
    end
    do_req(1'b0, 3'b010, BASE + 8, 32'h0, model_load(3'b010, 8), 1'b0, 0, "lw_after_rst");
  endtask

  task automatic test_random();
    logic [2:0]  f3_tab [5];
    logic [2:0]  f3;
    logic [31:0] data;
    int unsigned woff, off;
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
    for (int it = 0; it < 6; it++) begin
      woff = $urandom_range(0, DEPTH / 4 - 1) * 4;
      data = $urandom;
      do_req(1'b1, 3'b010, BASE + woff, data, 32'h0, 1'b0, 0, "rnd_sw");
      f3 = f3_tab[$urandom_range(0, 4)];
      if (f3[1:0] == 2'd0)      off = woff + $urandom_range(0, 3);
      else if (f3[1:0] == 2'd1) off = woff + 2 * $urandom_range(0, 1);
      else                      off = woff;
      do_req(1'b0, f3, BASE + off, 32'h0, model_load(f3, off), 1'b0, 0, "rnd_ld");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    strobe_cnt = 0;
    for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_store_load();
    test_extend();
    test_errors();
    test_hold();
    test_reset_in_access();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 Parameter BASE, default 32'h01000000: byte address of data-memory location 0.
REQ-002 Parameter MEM_DEPTH, default 32: data-memory size in bytes.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid is also high
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32 width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid is also high
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal funct3
- mem_read_write  out  1  data-memory write strobe
- mem_access_size  out  2  0=byte, 1=half, 2=word
- mem_address  out  32  data-memory byte address
- mem_data_in  out  32  data-memory write data
- mem_data_out  in  32  data-memory registered read data, little-endian

Function
REQ-004 FSM states: IDLE, ACCESS, LOAD_WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-005 On accept, register we, funct3, addr and wdata; leave IDLE.
REQ-006 Legal funct3 values:
- loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- stores: 000 SB, 001 SH, 010 SW
- anything else is illegal.
REQ-007 Error on accept: illegal funct3, or halfword address not 2-aligned, or word address not 4-aligned, or addr-BASE+size > MEM_DEPTH (unsigned, 33-bit compare). Then go IDLE->RESP with resp_err=1, resp_rdata=0, no memory write.
REQ-008 Legal request: IDLE->ACCESS.
- In ACCESS: mem_address = registered addr; mem_access_size = funct3[1:0]; mem_data_in = wdata; mem_read_write = we.
REQ-009 mem_read_write SHALL be 1 for exactly one cycle per legal store and 0 in every other state.
REQ-010 Store: ACCESS->RESP, resp_err=0, resp_rdata=0; resp_valid is first high 2 cycles after the accept edge.
REQ-011 Load: ACCESS->LOAD_WAIT.
- In LOAD_WAIT, sample mem_data_out and extend: LB/LH sign-extend bits [7:0]/[15:0]; LBU/LHU zero-extend; LW passes through.
- Register the result into resp_rdata; go to RESP. resp_valid is first high 3 cycles after the accept edge.
REQ-012 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL hold stable until resp_ready=1; then go to IDLE, with req_ready=1 on the next cycle (no back-to-back accept).
REQ-013 mem_* outputs outside ACCESS/LOAD_WAIT: read_write=0; address/size/data hold their last values.
REQ-014 The block SHALL NOT change req_* sampling behaviour based on resp_ready while in IDLE.

Reset
REQ-015 Reset asserted SHALL immediately force:
- state=IDLE
- req_ready=1
- resp_valid=0, resp_err=0, resp_rdata=0
- mem_read_write=0, mem_access_size=0, mem_address=BASE, mem_data_in=0
REQ-016 Reset during ACCESS SHALL drop mem_read_write immediately; the in-flight request is discarded and produces no response.

Structure
REQ-017 Shared package lsu_pkg SHALL hold the funct3 constants, the access-size encodings and the FSM state encoding.
REQ-018 One sub-module, lsu_load_extend (combinational: funct3, 32-bit word -> 32-bit result), SHALL implement REQ-011 extension.
REQ-019 The block's output mem_* ports SHALL connect port-for-port to the data-memory block; no logic between them.

Verification
REQ-020 SW addr=BASE+4 wdata=0xDEADBEEF, then LW same address -> single-cycle write strobe, size=2; load resp_rdata=0xDEADBEEF, resp_err=0, latency 3.
REQ-021 After REQ-020: LB BASE+7 -> 0xFFFFFFDE; LBU BASE+7 -> 0x000000DE; LH BASE+4 -> 0xFFFFBEEF; LHU BASE+6 -> 0x0000DEAD.
REQ-022 LW BASE+2 or SH BASE+1 -> resp_err=1, resp_rdata=0, mem_read_write never 1, response 1 cycle after accept.
REQ-023 LW BASE+MEM_DEPTH-2, SB BASE-1, funct3=011 -> each resp_err=1; no memory change (re-read BASE+4 is still 0xDEADBEEF).
REQ-024 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable; req_ready=0 throughout.
REQ-025 Assert reset in ACCESS of an SW -> mem_read_write=0 the same cycle, no resp_valid; after reset, req_ready=1.
